// File: rtl/seven_seg_pkg.sv
// Shared types, segment constants and BCD decode for the 4-digit 7-segment scan driver.
package seven_seg_pkg;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  // Active-high {g,f,e,d,c,b,a}; non-decimal codes render as a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_tick_divider.sv
// Free-running modulo-N counter with synchronous clear and a terminal-count pulse.
module tick_divider #(
  parameter int N = 10,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         run,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = run && (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: per-frame snapshot, guard interval,
// leading-zero blanking and whole-display flashing. Outputs are registered.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SCAN_HZ    = 250,
  parameter int GUARD_CYC  = 16,
  parameter int BLINK_HZ   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_mask,
  input  logic       blank_lead,
  input  logic       flash,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int   DIGIT_CYC = CLK_FREQ / (SCAN_HZ * 4);
  localparam int   HALF_CYC  = CLK_FREQ / (2 * BLINK_HZ);
  localparam int   SLOT_W    = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam int   BLINK_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic INV       = (ACTIVE_LOW != 0);

  generate
    if (!(DIGIT_CYC > GUARD_CYC && GUARD_CYC >= 1)) begin : g_bad_params
      $error("seven_seg_scan_driver: need DIGIT_CYC > GUARD_CYC >= 1");
    end
  endgenerate

  scan_state_t      state, state_next;
  digit_idx_t       idx, idx_next;
  logic [3:0][3:0]  snap_dig, nxt_dig;
  logic [3:0]       snap_mask, nxt_mask;
  logic             snap_blank, nxt_blank;
  logic             load;

  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_tick;
  logic [BLINK_W-1:0] blink_cnt_unused;
  logic               blink_tick;
  logic               blink_on;

  logic [6:0] seg_next;
  logic       dp_next;
  logic [3:0] an_next;
  logic       blanked;
  logic       lit;

  // Slot timer restarts with every new frame out of IDLE; it wraps exactly at the slot end.
  tick_divider #(.N(DIGIT_CYC)) u_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == IDLE) || !en),
    .run  (1'b1),
    .cnt  (slot_cnt),
    .tick (slot_tick)
  );

  tick_divider #(.N(HALF_CYC)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .clr  (!flash || !en),
    .run  (1'b1),
    .cnt  (blink_cnt_unused),
    .tick (blink_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || !flash || !en) begin
      blink_on <= 1'b0;
    end else if (blink_tick) begin
      blink_on <= !blink_on;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    if (rst || !en) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          load       = 1'b1;
        end
        BLANK: begin
          if (slot_cnt == SLOT_W'(GUARD_CYC - 1)) state_next = DRIVE;
        end
        DRIVE: begin
          if (slot_tick) begin
            state_next = BLANK;
            idx_next   = idx + 2'd1;
            load       = (idx == 2'd3);
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign nxt_dig   = load ? {digit3, digit2, digit1, digit0} : snap_dig;
  assign nxt_mask  = load ? dp_mask : snap_mask;
  assign nxt_blank = load ? blank_lead : snap_blank;

  // Outputs are derived from next-state values so the registered pins line up with the state.
  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    an_next  = 4'b0000;
    blanked  = nxt_blank &&
               (((idx_next == 2'd3) && (nxt_dig[3] == 4'd0)) ||
                ((idx_next == 2'd2) && (nxt_dig[3] == 4'd0) && (nxt_dig[2] == 4'd0)));
    lit      = 1'b0;
    if (state_next != IDLE) begin
      seg_next = decode_digit(nxt_dig[idx_next]);
      dp_next  = nxt_mask[idx_next];
      lit      = (state_next == DRIVE) && !blanked && !(flash && !blink_on);
      if (lit) an_next = 4'b0001 << idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      snap_dig   <= '0;
      snap_mask  <= '0;
      snap_blank <= 1'b0;
      seg        <= SEG_OFF ^ {7{INV}};
      dp         <= INV;
      an         <= {4{INV}};
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      snap_dig   <= nxt_dig;
      snap_mask  <= nxt_mask;
      snap_blank <= nxt_blank;
      seg        <= seg_next ^ {7{INV}};
      dp         <= dp_next ^ INV;
      an         <= an_next ^ {4{INV}};
      frame_tick <= load;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: constant vectors, hand-written corner sequences and
// randomized traffic, all checked every cycle against a frame-time reference model.
module tb_seven_seg_scan_driver;

  localparam int CLK_FREQ  = 1000;
  localparam int SCAN_HZ   = 25;
  localparam int GUARD_CYC = 2;
  localparam int BLINK_HZ  = 5;
  localparam int DIGIT_CYC = CLK_FREQ / (SCAN_HZ * 4);
  localparam int HALF      = CLK_FREQ / (2 * BLINK_HZ);
  localparam int FRAME     = 4 * DIGIT_CYC;

  logic       clk = 1'b0;
  logic       rst, en, blank_lead, flash;
  logic [3:0] digit3, digit2, digit1, digit0, dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit         m_active = 0;
  int         m_t = 0;
  int         m_fc = 0;
  bit         m_tick = 0;
  logic [3:0] m_dig[4];
  logic [3:0] m_mask;
  bit         m_blank;
  logic [12:0] m_exp;

  typedef struct {
    string      name;
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] mask;
    logic       bl;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs[12];

  seven_seg_scan_driver #(
    .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .GUARD_CYC(GUARD_CYC),
    .BLINK_HZ(BLINK_HZ), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dp_mask(dp_mask), .blank_lead(blank_lead), .flash(flash),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] lut[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d < 4'd10) ? lut[d] : 7'h40;
  endfunction

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_edge();
    int  slot, pos;
    bit  lit;
    m_tick = 0;
    if (rst || !en) begin
      m_active = 0;
      m_fc     = 0;
    end else begin
      m_fc = flash ? m_fc + 1 : 0;
      if (!m_active || m_t == FRAME - 1) begin
        m_active = 1;
        m_t      = 0;
        m_dig[0] = digit0; m_dig[1] = digit1; m_dig[2] = digit2; m_dig[3] = digit3;
        m_mask   = dp_mask;
        m_blank  = blank_lead;
        m_tick   = 1;
      end else begin
        m_t++;
      end
    end
    if (!m_active) begin
      m_exp = {1'b0, 4'hF, 1'b1, 7'h7F};
    end else begin
      slot = m_t / DIGIT_CYC;
      pos  = m_t % DIGIT_CYC;
      lit  = (pos >= GUARD_CYC);
      if (m_blank && slot == 3 && m_dig[3] == 0) lit = 0;
      if (m_blank && slot == 2 && m_dig[3] == 0 && m_dig[2] == 0) lit = 0;
      if (flash && (((m_fc - 1) / HALF) % 2 == 0)) lit = 0;
      m_exp = {m_tick, lit ? ~(4'b0001 << slot) : 4'hF, ~m_mask[slot], ~seg_of(m_dig[slot])};
    end
  endtask

  task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got tick=%0b an=%h dp=%0b seg=%h, want tick=%0b an=%h dp=%0b seg=%h",
               name, $time, act[12], act[11:8], act[7], act[6:0],
               exp[12], exp[11:8], exp[7], exp[6:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp("model", {frame_tick, an, dp, seg}, m_exp);
  endtask

  task automatic run_to(input int target);
    int n = 0;
    step();
    while (!(m_active && m_t == target) && n < 4 * FRAME) begin
      step();
      n++;
    end
    if (n >= 4 * FRAME) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to: frame position %0d not reached, now %0d", target, m_t);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  function automatic logic [3:0] rand_digit();
    return ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    vecs[0]  = '{"plain_s0", 1, 2, 3, 4,   4'b0100, 0, 0, 4'hE, 7'h19, 1'b1};
    vecs[1]  = '{"plain_s1", 1, 2, 3, 4,   4'b0100, 0, 1, 4'hD, 7'h30, 1'b1};
    vecs[2]  = '{"plain_s2", 1, 2, 3, 4,   4'b0100, 0, 2, 4'hB, 7'h24, 1'b0};
    vecs[3]  = '{"plain_s3", 1, 2, 3, 4,   4'b0100, 0, 3, 4'h7, 7'h79, 1'b1};
    vecs[4]  = '{"lz_s3",    0, 0, 0, 7,   4'b0000, 1, 3, 4'hF, 7'h40, 1'b1};
    vecs[5]  = '{"lz_s2",    0, 0, 0, 7,   4'b0000, 1, 2, 4'hF, 7'h40, 1'b1};
    vecs[6]  = '{"lz_s1",    0, 0, 0, 7,   4'b0000, 1, 1, 4'hD, 7'h40, 1'b1};
    vecs[7]  = '{"lz_s0",    0, 0, 0, 7,   4'b0000, 1, 0, 4'hE, 7'h78, 1'b1};
    vecs[8]  = '{"lz1_s3",   0, 5, 0, 7,   4'b0000, 1, 3, 4'hF, 7'h40, 1'b1};
    vecs[9]  = '{"lz1_s2",   0, 5, 0, 7,   4'b0000, 1, 2, 4'hB, 7'h12, 1'b1};
    vecs[10] = '{"dash_s0",  1, 2, 3, 4'hC, 4'b0001, 0, 0, 4'hE, 7'h3F, 1'b0};
    vecs[11] = '{"nolz_s3",  0, 0, 0, 0,   4'b1000, 0, 3, 4'h7, 7'h40, 1'b0};

    rst = 1; en = 1; flash = 0; blank_lead = 0; dp_mask = 4'b0100;
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);

    // reset holds everything dark even with en=1
    repeat (5) begin
      step();
      cmp("reset", {frame_tick, an, dp, seg}, {1'b0, 4'hF, 1'b1, 7'h7F});
    end

    rst = 0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    cmp("first_frame", {frame_tick, an, dp, seg}, {1'b1, 4'hF, 1'b1, 7'h19});
    run_to(FRAME - 1);
    step();
    cmp("frame_period", {frame_tick, an, dp, seg}, {1'b1, 4'hF, 1'b1, 7'h19});

    for (int i = 0; i < 12; i++) begin
      set_digits(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
      dp_mask = vecs[i].mask;
      blank_lead = vecs[i].bl;
      en = 0;
      step();
      en = 1;
      step();
      run_to(vecs[i].slot * DIGIT_CYC + 5);
      cmp(vecs[i].name, {an, dp, seg}, {1'b0, vecs[i].an, vecs[i].dp, vecs[i].seg});
    end

    // snapshot: digit0 change mid-frame waits for the next frame
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_mask = 4'b0000; blank_lead = 0;
    en = 0; step(); en = 1; step();
    run_to(3);
    digit0 = 4'd9;
    run_to(7);
    cmp("snap_hold_s0", {an, seg}, {1'b0, 4'hE, 7'h19});
    run_to(15);
    run_to(5);
    cmp("snap_new_s0", {an, seg}, {1'b0, 4'hE, 7'h10});

    // en dropped mid-DRIVE of slot 2, then re-raised
    run_to(25);
    en = 0;
    step();
    cmp("en_drop", {frame_tick, an, dp, seg}, {1'b0, 4'hF, 1'b1, 7'h7F});
    step();
    en = 1;
    step();
    cmp("en_rise", {frame_tick, an}, {1'b1, 4'hF});
    step();
    cmp("en_guard", {frame_tick, an}, {1'b0, 4'hF});
    run_to(5);
    cmp("en_slot0", {an, seg}, {4'hE, 7'h10});

    // flash: OFF phase first, then ON, and release takes effect at once
    set_digits(4'd1, 4'd2, 4'd3, 4'hC);
    run_to(0);
    flash = 1;
    run_to(5);
    cmp("flash_off", {1'b0, an}, {1'b0, 4'hF});
    repeat (100) step();
    cmp("flash_on", {1'b0, an}, {1'b0, 4'hB});
    repeat (100) step();
    cmp("flash_off2", {1'b0, an}, {1'b0, 4'hF});
    flash = 0;
    step();
    cmp("flash_release", {an, seg}, {4'hE, 7'h3F});

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
        dp_mask = 4'($urandom_range(0, 15));
        blank_lead = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) flash = ~flash;
      if (!en) en = 1;
      else if ($urandom_range(0, 399) == 0) en = 0;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Drives a 4-digit multiplexed 7-segment display from four BCD digits: {min_tens, min_ones, sec_tens, sec_ones} of the stopwatch/timer block.
- Sits between the time-keeping logic and the board pins. It is the display-side consumer of the digit bus.
- Provides tear-free frame snapshots, an anti-ghosting guard interval, optional leading-zero blanking, and whole-display flashing (e.g. driven by timer done).

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- SCAN_HZ, 250, full-frame refresh rate in Hz. DIGIT_CYC = CLK_FREQ/(SCAN_HZ*4) clocks per digit slot.
- GUARD_CYC, 16, clocks per slot with all anodes off before the digit is driven. Elaboration $error unless DIGIT_CYC > GUARD_CYC >= 1.
- BLINK_HZ, 2, flash rate. Half period = CLK_FREQ/(2*BLINK_HZ) clocks.
- ACTIVE_LOW, 1, when 1 the seg, dp and an outputs are inverted (common-anode board).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  display enable
- digit3  in  4  min_tens
- digit2  in  4  min_ones
- digit1  in  4  sec_tens
- digit0  in  4  sec_ones
- dp_mask  in  4  decimal point per digit (bit i = digit i)
- blank_lead  in  1  enable leading-zero blanking
- flash  in  1  blink the whole display
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point, registered
- an  out  4  anode select, bit i = digit i, registered
- frame_tick  out  1  1-cycle pulse when the snapshot loads

Behaviour:
- Reset (and whenever en=0): an all inactive, seg all off, dp off. With ACTIVE_LOW=1 this is an=4'hF, seg=7'h7F, dp=1. Also: frame_tick=0, slot counter=0, digit index=0, blink counter=0, blink phase=OFF. Reset takes effect at the next clk edge.
- FSM states:
  - IDLE: entered on rst or en=0. Leaves to BLANK on the first cycle with en=1. On that transition: snapshot digits/dp_mask/blank_lead, assert frame_tick, set index=0.
  - BLANK: GUARD_CYC cycles. Anodes off; seg/dp already hold the pattern for the current index.
  - DRIVE: DIGIT_CYC-GUARD_CYC cycles. Anode of the current index active, unless blanked or the flash phase is OFF.
    - At the end of DRIVE: index = index+1 mod 4, back to BLANK.
    - On wrap 3->0: reload the snapshot and pulse frame_tick in the same cycle as the transition into BLANK.
- Scan order: index 0,1,2,3 (sec_ones first). Period = 4*DIGIT_CYC clocks, exact, no drift.
- Snapshot: input changes mid-frame are invisible until the next frame_tick. Worst-case latency is 4*DIGIT_CYC+1 clocks.
- Decode (active-high, before polarity):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Values 10-15 show '-' (40).
  - dp = snapshot dp_mask[index].
- Leading-zero blanking (snapshot blank_lead=1):
  - digit3 blanked if it is 0.
  - digit2 blanked if digit3 and digit2 are both 0.
  - digit1 and digit0 are never blanked.
  - A blanked digit keeps its slot timing with its anode held inactive.
- Flash:
  - flash=0: blink counter held 0, phase OFF, no effect on output.
  - flash=1: counter runs and phase toggles every half period, starting OFF. All anodes are inactive while the phase is OFF. Slot timing is unaffected.
  - flash deasserting clears the counter on the next edge.
- Priority, per cycle: rst > en=0 > normal.
  - en falling in the same cycle as a slot boundary goes to IDLE.
  - en re-rising restarts at index 0 with a fresh snapshot.
- The blink counter width is $clog2 of its half period.

Decomposition:
- Package seven_seg_pkg holds:
  - digit decode function (4-bit -> 7-bit, active-high)
  - segment constants SEG_DASH, SEG_OFF
  - state enum {IDLE, BLANK, DRIVE}
  - 2-bit digit index typedef
- Sub-module tick_divider: parameterized free-running counter with sync clear and terminal pulse. Instantiated twice, for the slot timer and the blink timer.

Test Plan (CLK_FREQ=1000, SCAN_HZ=25 -> DIGIT_CYC=10, GUARD_CYC=2, BLINK_HZ=5 -> half period 100, ACTIVE_LOW=1):
1. rst=1 for 5 cycles with en=1 and arbitrary digits -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0 throughout.
2. Reset released, en=1, digits {3,2,1,0}={1,2,3,4}, dp_mask=4'b0100 -> frame_tick pulses, then per slot:
   - slot 0: 2 cycles an=F, then 8 cycles an=E with seg=19
   - slot 1: an=D, seg=30
   - slot 2: an=B, seg=24, dp=0
   - slot 3: an=7, seg=79
   - frame_tick repeats every 40 cycles
3. Change digit0 to 9 mid-slot 1 -> seg stays 19 in slot 0 until after the next frame_tick, then 10.
4. blank_lead=1, digits {0,0,0,7} -> slots 3 and 2 keep an=F, slot 1 shows seg=40 on an=D, slot 0 shows seg=78. Same test with digit3=0, digit2=5 -> only slot 3 blanked.
5. digit0=4'hC -> slot 0 seg=3F ('-'). flash=1 -> anodes all F for 100 cycles, then normal scanning for 100, repeating. flash=0 -> scanning resumes next cycle.
6. en dropped mid-DRIVE of slot 2 -> next cycle an=F, seg=7F. en re-raised -> frame_tick pulses and scanning restarts at slot 0 with the guard interval.
